// File: rtl/msrh_lsu_replay_sched.sv
// Replay scheduler for one LSU pipe.
// Each memory-queue entry that hit a hazard waits here until its wake-up
// event arrives. Ready entries are offered to the EX0 replay port one per
// cycle, in round-robin order. The payload stays in the LDQ/STQ; this block
// only keeps per-entry wait state.
module msrh_lsu_replay_sched #(
    parameter int ENTRY_SIZE  = 16,
    parameter int LRQ_SIZE    = 8,
    parameter int RETRY_DELAY = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_hazard_vld,
    input  logic [ENTRY_SIZE-1:0]         i_hazard_index_oh,
    input  logic [2:0]                    i_hazard_typ,
    input  logic [LRQ_SIZE-1:0]           i_hazard_lrq_index_oh,
    input  logic                          i_tlb_resolve,
    input  logic [LRQ_SIZE-1:0]           i_lrq_resolve_index_oh,
    input  logic                          i_lrq_free,
    input  logic [ENTRY_SIZE-1:0]         i_done_index_oh,
    output logic                          o_replay_valid,
    output logic [ENTRY_SIZE-1:0]         o_replay_index_oh,
    input  logic                          i_replay_ready,
    output logic [$clog2(ENTRY_SIZE):0]   o_wait_count
);

    localparam int PTR_W = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1;
    localparam int CNT_W = $clog2(ENTRY_SIZE) + 1;

    localparam logic [2:0] HZ_NONE         = 3'd0;
    localparam logic [2:0] HZ_TLB_MISS     = 3'd1;
    localparam logic [2:0] HZ_L1D_CONFLICT = 3'd2;
    localparam logic [2:0] HZ_LRQ_ASSIGNED = 3'd3;
    localparam logic [2:0] HZ_LRQ_CONFLICT = 3'd4;

    // The capture edge already counts as the first of the RETRY_DELAY cycles,
    // so the counter holds the number of WAIT cycles still to go.
    localparam logic [3:0] DELAY_RELOAD = 4'(RETRY_DELAY - 1);
    localparam logic       DELAY_IS_ONE = (RETRY_DELAY <= 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } state_t;

    logic [ENTRY_SIZE-1:0] w_ready_vec;
    logic [ENTRY_SIZE-1:0] w_active_next_vec;
    logic [ENTRY_SIZE-1:0] w_grant_oh;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_sel_idx;
    logic                  w_sel_found;
    logic [PTR_W:0]        w_scan_sum;
    logic [PTR_W-1:0]      w_scan_idx;
    logic [CNT_W-1:0]      r_wait_count;
    logic [CNT_W-1:0]      w_wait_count_next;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRY_SIZE; gi++) begin : g_entry
            state_t             r_state;
            state_t             w_state_next;
            logic [2:0]         r_typ;
            logic [2:0]         w_typ_next;
            logic [LRQ_SIZE-1:0] r_lrq_oh;
            logic [LRQ_SIZE-1:0] w_lrq_next;
            logic [3:0]         r_cnt;
            logic [3:0]         w_cnt_next;
            logic               w_hazard_hit;
            logic               w_cap_wake;
            logic               w_wait_wake;

            assign w_hazard_hit          = i_hazard_vld & i_hazard_index_oh[gi];
            assign w_ready_vec[gi]       = (r_state == ST_READY);
            assign w_grant_oh[gi]        = o_replay_index_oh[gi] & i_replay_ready;
            assign w_active_next_vec[gi] = (w_state_next == ST_WAIT) || (w_state_next == ST_READY);

            // Wake-up test for a hazard being captured this cycle (uses the incoming report)
            always_comb begin
                w_cap_wake = 1'b1;
                case (i_hazard_typ)
                    HZ_NONE:         w_cap_wake = 1'b1;
                    HZ_TLB_MISS:     w_cap_wake = i_tlb_resolve;
                    HZ_L1D_CONFLICT: w_cap_wake = DELAY_IS_ONE;
                    HZ_LRQ_ASSIGNED: w_cap_wake = |(i_lrq_resolve_index_oh & i_hazard_lrq_index_oh);
                    HZ_LRQ_CONFLICT: w_cap_wake = i_lrq_free;
                    default:         w_cap_wake = 1'b1;
                endcase
            end

            // Wake-up test for an entry already waiting (uses the stored cause)
            always_comb begin
                w_wait_wake = 1'b1;
                case (r_typ)
                    HZ_NONE:         w_wait_wake = 1'b1;
                    HZ_TLB_MISS:     w_wait_wake = i_tlb_resolve;
                    HZ_L1D_CONFLICT: w_wait_wake = (r_cnt <= 4'd1);
                    HZ_LRQ_ASSIGNED: w_wait_wake = |(i_lrq_resolve_index_oh & r_lrq_oh);
                    HZ_LRQ_CONFLICT: w_wait_wake = i_lrq_free;
                    default:         w_wait_wake = 1'b1;
                endcase
            end

            // Entry next state: done beats hazard capture, which beats grant and wake-up
            always_comb begin
                w_state_next = r_state;
                w_typ_next   = r_typ;
                w_lrq_next   = r_lrq_oh;
                w_cnt_next   = r_cnt;
                if (i_done_index_oh[gi]) begin
                    w_state_next = ST_IDLE;
                end else if (w_hazard_hit) begin
                    w_typ_next   = i_hazard_typ;
                    w_lrq_next   = i_hazard_lrq_index_oh;
                    w_cnt_next   = (i_hazard_typ == HZ_L1D_CONFLICT) ? DELAY_RELOAD : 4'd0;
                    w_state_next = w_cap_wake ? ST_READY : ST_WAIT;
                end else if (w_grant_oh[gi]) begin
                    w_state_next = ST_ISSUED;
                end else if (r_state == ST_WAIT) begin
                    if (w_wait_wake) begin
                        w_state_next = ST_READY;
                    end else if (r_typ == HZ_L1D_CONFLICT) begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
            end

            // Entry state register
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_state  <= ST_IDLE;
                    r_typ    <= HZ_NONE;
                    r_lrq_oh <= '0;
                    r_cnt    <= 4'd0;
                end else begin
                    r_state  <= w_state_next;
                    r_typ    <= w_typ_next;
                    r_lrq_oh <= w_lrq_next;
                    r_cnt    <= w_cnt_next;
                end
            end
        end
    endgenerate

    // Round-robin pick: first READY entry at or after the pointer, wrapping
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < ENTRY_SIZE; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_scan_sum >= (PTR_W+1)'(ENTRY_SIZE)) begin
                w_scan_sum = w_scan_sum - (PTR_W+1)'(ENTRY_SIZE);
            end
            w_scan_idx = w_scan_sum[PTR_W-1:0];
            if (!w_sel_found && w_ready_vec[w_scan_idx]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_scan_idx;
            end
        end
    end

    assign o_replay_valid    = w_sel_found;
    assign o_replay_index_oh = w_sel_found ? (ENTRY_SIZE'(1) << w_sel_idx) : '0;

    // Pointer moves past the granted entry; held while EX0 is not ready
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (o_replay_valid && i_replay_ready) begin
            r_rr_ptr <= (w_sel_idx == PTR_W'(ENTRY_SIZE - 1)) ? '0 : w_sel_idx + PTR_W'(1);
        end
    end

    // Population count of entries that will be WAIT or READY after this edge
    always_comb begin
        w_wait_count_next = '0;
        for (int k = 0; k < ENTRY_SIZE; k++) begin
            w_wait_count_next = w_wait_count_next + CNT_W'(w_active_next_vec[k]);
        end
    end

    // Registered wait count
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wait_count <= '0;
        end else begin
            r_wait_count <= w_wait_count_next;
        end
    end

    assign o_wait_count = r_wait_count;

endmodule

// File: tb/tb_msrh_lsu_replay_sched.sv
// Testbench for msrh_lsu_replay_sched: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model of the scheduler.
module tb_msrh_lsu_replay_sched;

    localparam int E  = 16;
    localparam int L  = 8;
    localparam int RD = 4;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_TLB  = 3'd1;
    localparam logic [2:0] T_L1D  = 3'd2;
    localparam logic [2:0] T_LRQA = 3'd3;
    localparam logic [2:0] T_LRQC = 3'd4;

    localparam int S_IDLE   = 0;
    localparam int S_WAIT   = 1;
    localparam int S_READY  = 2;
    localparam int S_ISSUED = 3;

    logic           clk;
    logic           i_reset;
    logic           i_hazard_vld;
    logic [E-1:0]   i_hazard_index_oh;
    logic [2:0]     i_hazard_typ;
    logic [L-1:0]   i_hazard_lrq_index_oh;
    logic           i_tlb_resolve;
    logic [L-1:0]   i_lrq_resolve_index_oh;
    logic           i_lrq_free;
    logic [E-1:0]   i_done_index_oh;
    logic           o_replay_valid;
    logic [E-1:0]   o_replay_index_oh;
    logic           i_replay_ready;
    logic [4:0]     o_wait_count;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model: per-entry state, cause, LRQ slot, and absolute cycle
    // at which an L1D-conflicted entry is due to become ready.
    int         m_st[E];
    int         m_typ[E];
    logic [L-1:0] m_lrq[E];
    int         m_ready_at[E];
    int         m_ptr;
    int         cyc;

    msrh_lsu_replay_sched #(
        .ENTRY_SIZE (E),
        .LRQ_SIZE   (L),
        .RETRY_DELAY(RD)
    ) dut (
        .i_clk                 (clk),
        .i_reset               (i_reset),
        .i_hazard_vld          (i_hazard_vld),
        .i_hazard_index_oh     (i_hazard_index_oh),
        .i_hazard_typ          (i_hazard_typ),
        .i_hazard_lrq_index_oh (i_hazard_lrq_index_oh),
        .i_tlb_resolve         (i_tlb_resolve),
        .i_lrq_resolve_index_oh(i_lrq_resolve_index_oh),
        .i_lrq_free            (i_lrq_free),
        .i_done_index_oh       (i_done_index_oh),
        .o_replay_valid        (o_replay_valid),
        .o_replay_index_oh     (o_replay_index_oh),
        .i_replay_ready        (i_replay_ready),
        .o_wait_count          (o_wait_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_sel();
        for (int k = 0; k < E; k++) begin
            if (m_st[(m_ptr + k) % E] == S_READY) return (m_ptr + k) % E;
        end
        return -1;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int e = 0; e < E; e++) if (m_st[e] == S_WAIT || m_st[e] == S_READY) n++;
        return n;
    endfunction

    function automatic logic [E-1:0] model_idx_oh();
        int s = model_sel();
        logic [E-1:0] v = '0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    // Has the stored cause of entry e been satisfied at the coming edge?
    function automatic bit woken(int e);
        case (m_typ[e])
            0:       return 1'b1;
            1:       return i_tlb_resolve;
            2:       return (cyc + 1 >= m_ready_at[e]);
            3:       return (i_lrq_resolve_index_oh & m_lrq[e]) != '0;
            4:       return i_lrq_free;
            default: return 1'b1;
        endcase
    endfunction

    task automatic clear_inputs();
        i_reset                = 1'b0;
        i_hazard_vld           = 1'b0;
        i_hazard_index_oh      = '0;
        i_hazard_typ           = T_NONE;
        i_hazard_lrq_index_oh  = '0;
        i_tlb_resolve          = 1'b0;
        i_lrq_resolve_index_oh = '0;
        i_lrq_free             = 1'b0;
        i_done_index_oh        = '0;
        i_replay_ready         = 1'b0;
    endtask

    task automatic hazard(input int e, input logic [2:0] t, input logic [L-1:0] lrq);
        i_hazard_vld          = 1'b1;
        i_hazard_index_oh     = '0;
        i_hazard_index_oh[e]  = 1'b1;
        i_hazard_typ          = t;
        i_hazard_lrq_index_oh = lrq;
    endtask

    // Advance one clock: update the model from the inputs now applied, then
    // step the DUT and return at the following falling edge.
    task automatic tick();
        int  sel;
        bit  grant;
        sel   = model_sel();
        grant = (sel >= 0) && (i_replay_ready === 1'b1);
        if (i_reset) begin
            for (int e = 0; e < E; e++) begin
                m_st[e] = S_IDLE; m_typ[e] = 0; m_lrq[e] = '0; m_ready_at[e] = 0;
            end
            m_ptr = 0;
        end else begin
            for (int e = 0; e < E; e++) begin
                if (i_done_index_oh[e]) begin
                    m_st[e] = S_IDLE;
                end else if (i_hazard_vld && i_hazard_index_oh[e]) begin
                    m_typ[e]      = int'(i_hazard_typ);
                    m_lrq[e]      = i_hazard_lrq_index_oh;
                    m_ready_at[e] = cyc + RD;
                    m_st[e]       = woken(e) ? S_READY : S_WAIT;
                end else if (grant && e == sel) begin
                    m_st[e] = S_ISSUED;
                end else if (m_st[e] == S_WAIT && woken(e)) begin
                    m_st[e] = S_READY;
                end
            end
            if (grant) begin
                $display("cycle %0d: replay grant entry %0d", cyc, sel);
                m_ptr = (sel + 1) % E;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        i_reset = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        #1;
        vectors++;
        if (o_replay_valid !== 1'b0) begin
            $display("FAIL reset_valid: got %0b want 0", o_replay_valid); errors++;
        end
        vectors++;
        if (o_replay_index_oh !== 16'h0000) begin
            $display("FAIL reset_index: got %h want 0000", o_replay_index_oh); errors++;
        end
        vectors++;
        if (o_wait_count !== 5'd0) begin
            $display("FAIL reset_count: got %0d want 0", o_wait_count); errors++;
        end
    endtask

    task automatic test_tlb_miss();
        do_reset();
        hazard(3, T_TLB, '0);
        tick();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (o_replay_valid !== 1'b0) begin
                $display("FAIL tlb_early_valid: got %0b want 0 (wait cycle %0d)", o_replay_valid, k); errors++;
            end
            tick();
        end
        i_tlb_resolve = 1'b1;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_replay_valid !== 1'b1 || o_replay_index_oh !== 16'h0008) begin
            $display("FAIL tlb_wake: got valid=%0b idx=%h want valid=1 idx=0008", o_replay_valid, o_replay_index_oh); errors++;
        end
        i_replay_ready = 1'b1;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_replay_valid !== 1'b0 || o_wait_count !== 5'd0) begin
            $display("FAIL tlb_issued: got valid=%0b count=%0d want valid=0 count=0", o_replay_valid, o_wait_count); errors++;
        end
    endtask

    task automatic test_l1d_delay();
        do_reset();
        hazard(5, T_L1D, '0);
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_wait_count !== 5'd1) begin
            $display("FAIL l1d_count: got %0d want 1", o_wait_count); errors++;
        end
        for (int k = 1; k < RD; k++) begin
            #1;
            vectors++;
            if (o_replay_valid !== 1'b0) begin
                $display("FAIL l1d_early_valid: got %0b want 0 at %0d cycles after capture", o_replay_valid, k); errors++;
            end
            tick();
        end
        #1;
        vectors++;
        if (o_replay_valid !== 1'b1 || o_replay_index_oh !== 16'h0020) begin
            $display("FAIL l1d_ready: got valid=%0b idx=%h want valid=1 idx=0020", o_replay_valid, o_replay_index_oh); errors++;
        end
    endtask

    task automatic test_lrq_assigned();
        do_reset();
        hazard(1, T_LRQA, 8'h04); tick();
        hazard(2, T_LRQA, 8'h04); tick();
        hazard(6, T_LRQA, 8'h01); tick();
        clear_inputs();
        i_lrq_resolve_index_oh = 8'h04;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_replay_index_oh !== 16'h0002 || o_wait_count !== 5'd3) begin
            $display("FAIL lrq_first: got idx=%h count=%0d want idx=0002 count=3", o_replay_index_oh, o_wait_count); errors++;
        end
        i_replay_ready = 1'b1;
        tick();
        #1;
        vectors++;
        if (o_replay_index_oh !== 16'h0004) begin
            $display("FAIL lrq_second: got idx=%h want 0004", o_replay_index_oh); errors++;
        end
        tick();
        #1;
        vectors++;
        if (o_replay_valid !== 1'b0 || o_wait_count !== 5'd1) begin
            $display("FAIL lrq_entry6_waits: got valid=%0b count=%0d want valid=0 count=1", o_replay_valid, o_wait_count); errors++;
        end
        i_replay_ready = 1'b0;
        i_lrq_resolve_index_oh = 8'h01;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_replay_index_oh !== 16'h0040) begin
            $display("FAIL lrq_entry6_wake: got idx=%h want 0040", o_replay_index_oh); errors++;
        end
    endtask

    task automatic test_rr_wrap();
        logic [E-1:0] exp_order[3];
        exp_order[0] = 16'h8000;
        exp_order[1] = 16'h0001;
        exp_order[2] = 16'h0080;
        do_reset();
        // Grant entry 7 once so the pointer lands on 8
        hazard(7, T_NONE, '0);
        tick();
        clear_inputs();
        i_replay_ready = 1'b1;
        tick();
        clear_inputs();
        hazard(0, T_NONE, '0);  tick();
        hazard(7, T_NONE, '0);  tick();
        hazard(15, T_NONE, '0); tick();
        clear_inputs();
        i_replay_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (o_replay_index_oh !== exp_order[k]) begin
                $display("FAIL rr_order[%0d]: got idx=%h want %h", k, o_replay_index_oh, exp_order[k]); errors++;
            end
            tick();
        end
        #1;
        vectors++;
        if (o_replay_valid !== 1'b0) begin
            $display("FAIL rr_drained: got valid=%0b want 0", o_replay_valid); errors++;
        end
        clear_inputs();
    endtask

    task automatic test_same_cycle();
        do_reset();
        hazard(4, T_LRQC, '0);
        i_lrq_free = 1'b1;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_replay_valid !== 1'b1 || o_replay_index_oh !== 16'h0010 || o_wait_count !== 5'd1) begin
            $display("FAIL same_cycle_wake: got valid=%0b idx=%h count=%0d want 1/0010/1",
                     o_replay_valid, o_replay_index_oh, o_wait_count); errors++;
        end
        hazard(11, T_TLB, '0);
        i_done_index_oh = 16'h0800;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_wait_count !== 5'd1) begin
            $display("FAIL done_beats_hazard_count: got %0d want 1", o_wait_count); errors++;
        end
        i_tlb_resolve = 1'b1;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_replay_index_oh !== 16'h0010 || o_wait_count !== 5'd1) begin
            $display("FAIL done_beats_hazard_idle: got idx=%h count=%0d want 0010/1", o_replay_index_oh, o_wait_count); errors++;
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        hazard(1, T_TLB, '0);   tick();
        hazard(2, T_TLB, '0);   tick();
        hazard(3, T_LRQC, '0);  tick();
        hazard(10, T_NONE, '0); tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_wait_count !== 5'd4 || o_replay_valid !== 1'b1) begin
            $display("FAIL midflight_pre: got count=%0d valid=%0b want 4/1", o_wait_count, o_replay_valid); errors++;
        end
        i_reset = 1'b1;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_wait_count !== 5'd0 || o_replay_valid !== 1'b0) begin
            $display("FAIL midflight_reset: got count=%0d valid=%0b want 0/0", o_wait_count, o_replay_valid); errors++;
        end
        i_tlb_resolve = 1'b1;
        tick();
        clear_inputs();
        #1;
        vectors++;
        if (o_replay_valid !== 1'b0) begin
            $display("FAIL midflight_no_replay: got valid=%0b want 0", o_replay_valid); errors++;
        end
    endtask

    task automatic test_random();
        int sel;
        logic [E-1:0] exp_idx;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            clear_inputs();
            if ($urandom_range(0, 2) != 0) begin
                hazard(int'($urandom_range(0, E - 1)), 3'($urandom_range(0, 4)),
                       L'(1) << $urandom_range(0, L - 1));
            end
            i_tlb_resolve          = ($urandom_range(0, 5) == 0);
            i_lrq_free             = ($urandom_range(0, 5) == 0);
            i_lrq_resolve_index_oh = L'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) i_done_index_oh = E'(1) << $urandom_range(0, E - 1);
            i_replay_ready = $urandom_range(0, 1) == 1;
            sel = model_sel();
            if (i_hazard_vld && sel >= 0 && i_hazard_index_oh[sel]) i_replay_ready = 1'b0;
            #1;
            exp_idx = model_idx_oh();
            vectors++;
            if (o_replay_valid !== (sel >= 0)) begin
                $display("FAIL rand_valid cycle %0d: got %0b want %0b", cyc, o_replay_valid, sel >= 0); errors++;
            end
            vectors++;
            if (o_replay_index_oh !== exp_idx) begin
                $display("FAIL rand_index cycle %0d: got %h want %h", cyc, o_replay_index_oh, exp_idx); errors++;
            end
            vectors++;
            if (o_wait_count !== 5'(model_count())) begin
                $display("FAIL rand_count cycle %0d: got %0d want %0d", cyc, o_wait_count, model_count()); errors++;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        cyc = 0;
        m_ptr = 0;
        for (int e = 0; e < E; e++) begin
            m_st[e] = S_IDLE; m_typ[e] = 0; m_lrq[e] = '0; m_ready_at[e] = 0;
        end
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_tlb_miss();
        test_l1d_delay();
        test_lrq_assigned();
        test_rr_wrap();
        test_same_cycle();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
